// File: rtl/fpu_dma.sv
// DMA engine between byte memory and the FPU line buffers.
// Drains a write-buffer window to memory, then fills a read-buffer bank from memory.
module fpu_dma #(
    parameter int COL_WIDTH        = 10,
    parameter int MEM_BUFFER_WIDTH = 512,
    localparam int ROW_W           = $clog2(COL_WIDTH),
    localparam int COL_W           = $clog2(MEM_BUFFER_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             request_read,
    input  logic             request_write,
    input  logic [31:0]      read_address,
    input  logic [31:0]      write_address,
    input  logic [16:0]      write_request_width,
    input  logic [8:0]       write_request_height,
    input  logic [15:0]      image_width,
    input  logic             fill_sel,
    input  logic             drain_sel,
    output logic             making_request,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [7:0]       mem_rdata,
    output logic             rbuf_wr_en,
    output logic             rbuf_sel,
    output logic [ROW_W-1:0] rbuf_row,
    output logic [COL_W-1:0] rbuf_col,
    output logic [7:0]       rbuf_data,
    output logic             wbuf_rd_en,
    output logic             wbuf_sel,
    output logic [ROW_W-1:0] wbuf_row,
    output logic [COL_W-1:0] wbuf_col,
    input  logic [7:0]       wbuf_data
);

    localparam int DW_W = $clog2(MEM_BUFFER_WIDTH + 1);
    localparam int DH_W = $clog2(COL_WIDTH + 1);

    typedef enum logic [2:0] {IDLE, DR_FETCH, DR_MEM, FL_MEM, FL_WAIT, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_rd_addr;
    logic [31:0]      r_row_base;
    logic [15:0]      r_img_w;
    logic [DW_W-1:0]  r_dw;
    logic [DH_W-1:0]  r_dh;
    logic             r_fill_pend;
    logic             r_fill_sel;
    logic             r_drain_sel;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_rd_d;
    logic [7:0]       r_wdata;

    logic [DW_W-1:0]  w_dw;
    logic [DH_W-1:0]  w_dh;
    logic             w_req;
    logic             w_drain_ok;
    logic [31:0]      w_in_stride;
    logic [31:0]      w_out_stride;
    logic [31:0]      w_cur_addr;
    logic             w_dr_last_col;
    logic             w_dr_last_row;
    logic             w_fl_last_col;
    logic             w_fl_last_row;

    assign w_req      = request_read | request_write;
    assign w_dw       = (write_request_width > 17'(MEM_BUFFER_WIDTH)) ? DW_W'(MEM_BUFFER_WIDTH)
                                                                       : DW_W'(write_request_width);
    assign w_dh       = (write_request_height > 9'(COL_WIDTH)) ? DH_W'(COL_WIDTH)
                                                                : DH_W'(write_request_height);
    assign w_drain_ok = (w_dw != '0) && (w_dh != '0);

    // Row addresses are advanced by stride instead of multiplied; 32-bit adds wrap naturally.
    assign w_in_stride  = ({16'd0, r_img_w} + 32'd2) * 32'd3;
    assign w_out_stride = {16'd0, r_img_w} * 32'd3 + 32'd4;
    assign w_cur_addr   = r_row_base + 32'(r_col);

    assign w_dr_last_col = (DW_W'(r_col) == r_dw - DW_W'(1));
    assign w_dr_last_row = (DH_W'(r_row) == r_dh - DH_W'(1));
    assign w_fl_last_col = (r_col == COL_W'(MEM_BUFFER_WIDTH - 1));
    assign w_fl_last_row = (r_row == ROW_W'(COL_WIDTH - 1));

    always_comb begin
        w_state_next   = r_state;
        making_request = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        rbuf_wr_en     = 1'b0;
        rbuf_sel       = 1'b0;
        rbuf_row       = '0;
        rbuf_col       = '0;
        rbuf_data      = '0;
        wbuf_rd_en     = 1'b0;
        wbuf_sel       = 1'b0;
        wbuf_row       = '0;
        wbuf_col       = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (request_write && w_drain_ok) w_state_next = DR_FETCH;
                    else if (request_read)           w_state_next = FL_MEM;
                    else                             w_state_next = DONE;
                end
            end
            DR_FETCH: begin
                making_request = 1'b1;
                wbuf_rd_en     = 1'b1;
                wbuf_sel       = r_drain_sel;
                wbuf_row       = r_row;
                wbuf_col       = r_col;
                w_state_next   = DR_MEM;
            end
            DR_MEM: begin
                making_request = 1'b1;
                mem_req        = 1'b1;
                mem_we         = 1'b1;
                mem_addr       = w_cur_addr;
                // Buffer data arrives in the first DR_MEM cycle; held copy keeps it stable across stalls.
                mem_wdata      = r_rd_d ? wbuf_data : r_wdata;
                if (mem_gnt) begin
                    if (w_dr_last_col && w_dr_last_row) w_state_next = r_fill_pend ? FL_MEM : DONE;
                    else                                 w_state_next = DR_FETCH;
                end
            end
            FL_MEM: begin
                making_request = 1'b1;
                mem_req        = 1'b1;
                mem_addr       = w_cur_addr;
                if (mem_gnt) w_state_next = FL_WAIT;
            end
            FL_WAIT: begin
                making_request = 1'b1;
                if (mem_rvalid) begin
                    rbuf_wr_en   = 1'b1;
                    rbuf_sel     = r_fill_sel;
                    rbuf_row     = r_row;
                    rbuf_col     = r_col;
                    rbuf_data    = mem_rdata;
                    w_state_next = (w_fl_last_col && w_fl_last_row) ? DONE : FL_MEM;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd_addr   <= '0;
            r_row_base  <= '0;
            r_img_w     <= '0;
            r_dw        <= '0;
            r_dh        <= '0;
            r_fill_pend <= 1'b0;
            r_fill_sel  <= 1'b0;
            r_drain_sel <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_rd_d      <= 1'b0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_state_next;
            r_rd_d  <= (r_state == DR_FETCH);
            if (r_rd_d) r_wdata <= wbuf_data;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_rd_addr   <= read_address;
                        r_img_w     <= image_width;
                        r_dw        <= w_dw;
                        r_dh        <= w_dh;
                        r_fill_pend <= request_read;
                        r_fill_sel  <= fill_sel;
                        r_drain_sel <= drain_sel;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_row_base  <= (request_write && w_drain_ok) ? write_address : read_address;
                    end
                end
                DR_MEM: begin
                    if (mem_gnt) begin
                        if (w_dr_last_col) begin
                            r_col <= '0;
                            if (w_dr_last_row) begin
                                // Drain finished: rewind onto the fill window.
                                r_row      <= '0;
                                r_row_base <= r_rd_addr;
                            end else begin
                                r_row      <= r_row + ROW_W'(1);
                                r_row_base <= r_row_base + w_out_stride;
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                FL_WAIT: begin
                    if (mem_rvalid) begin
                        if (w_fl_last_col) begin
                            r_col      <= '0;
                            r_row      <= r_row + ROW_W'(1);
                            r_row_base <= r_row_base + w_in_stride;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fpu_dma.md
FPU_DMA -- requirements
Module: fpu_dma

Interface
REQ-001 Parameter: COL_WIDTH, 10, number of buffer rows per transfer.
REQ-002 Parameter: MEM_BUFFER_WIDTH, 512, number of buffer columns per row.
REQ-003 Port: clk  in  1  single clock; all logic updates on the rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: request_read  in  1  controller asks for a read-buffer fill.
REQ-006 Port: request_write  in  1  controller asks for a write-buffer drain.
REQ-007 Port: read_address  in  32  byte address of the first input pixel byte to fill.
REQ-008 Port: write_address  in  32  byte address of the first output byte to drain.
REQ-009 Port: write_request_width  in  17  bytes per row to drain.
REQ-010 Port: write_request_height  in  9  rows to drain.
REQ-011 Port: image_width  in  16  image width in pixels, used for row strides.
REQ-012 Port: fill_sel / drain_sel  in  1 each  read-buffer bank to fill / write-buffer bank to drain.
REQ-013 Port: making_request  out  1  transfer in progress.
REQ-014 Port: mem_req, mem_we  out  1 each  memory request strobe and write qualifier.
REQ-015 Port: mem_addr  out  32  memory byte address.
REQ-016 Port: mem_wdata  out  8  memory write data.
REQ-017 Port: mem_gnt, mem_rvalid  in  1 each  request accepted / read data valid.
REQ-018 Port: mem_rdata  in  8  memory read data.
REQ-019 Port: rbuf_wr_en, rbuf_sel  out  1 each  read-buffer write strobe and bank.
REQ-020 Port: rbuf_row, rbuf_col, rbuf_data  out  clog2(COL_WIDTH), clog2(MEM_BUFFER_WIDTH), 8  read-buffer write location and data.
REQ-021 Port: wbuf_rd_en, wbuf_sel  out  1 each  write-buffer read strobe and bank.
REQ-022 Port: wbuf_row, wbuf_col  out  widths as rbuf_row/rbuf_col  write-buffer read location.
REQ-023 Port: wbuf_data  in  8  write-buffer data, valid 1 cycle after wbuf_rd_en.

Function
REQ-024 States: IDLE, DR_FETCH, DR_MEM, FL_MEM, FL_WAIT, DONE.
REQ-025 Requests are sampled only in IDLE; in IDLE with either request high, the block latches all request inputs, asserts making_request from the next cycle, and goes to DR_FETCH if request_write else FL_MEM.
REQ-026 Drain runs first when both requests are high; the fill starts the cycle after the last drain write is granted.
REQ-027 Input row stride = (image_width+2)*3; output row stride = image_width*3+4; all address arithmetic is 32-bit and wraps modulo 2^32.
REQ-028 Drain clamps width to MEM_BUFFER_WIDTH and height to COL_WIDTH; a clamped width or height of 0 skips the drain.
REQ-029 Drain, row r and column c in row-major order: DR_FETCH pulses wbuf_rd_en for one cycle with wbuf_row=r, wbuf_col=c; DR_MEM then holds mem_req=1, mem_we=1, mem_addr=write_address+r*out_stride+c and mem_wdata=the registered wbuf_data until mem_gnt.
REQ-030 Fill covers COL_WIDTH x MEM_BUFFER_WIDTH bytes in row-major order: FL_MEM holds mem_req=1, mem_we=0, mem_addr=read_address+r*in_stride+c until mem_gnt; FL_WAIT waits for mem_rvalid.
REQ-031 When mem_rvalid is seen in FL_WAIT, rbuf_wr_en pulses in that same cycle with rbuf_data=mem_rdata and the current row, column and latched fill_sel.
REQ-032 Exactly one memory transaction is outstanding at any time; mem_rvalid outside FL_WAIT is ignored.
REQ-033 mem_req, mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_gnt=0.
REQ-034 After the final transfer, the FSM enters DONE for one cycle with making_request=0, then returns to IDLE.
REQ-035 Requests present in DONE are ignored.
REQ-036 Input changes while making_request=1 have no effect.

Reset
REQ-037 rst forces IDLE and clears all counters and latched values.
REQ-038 rst drives making_request, mem_req, mem_we, rbuf_wr_en and wbuf_rd_en to 0, and all addresses and data outputs to 0.
REQ-039 rst mid-transfer aborts the transfer at once; no further buffer or memory strobes are issued.

Verification
REQ-040 Fill only: image_width=225, read_address=0x100, mem_gnt tied high, rvalid 3 cycles after grant -> 5120 reads; the row-1 first address is 0x100+681=0x3A9; buffer bank = fill_sel; making_request falls after the last rbuf_wr_en.
REQ-041 Drain only: width=10, height=2, write_address=0x2000, image_width=4 -> 20 writes; the row-1 first address is 0x2010; mem_wdata equals the wbuf_data from the matching row and column.
REQ-042 Both requests: the last drain write precedes the first fill read; each of making_request's rising and falling edges occurs exactly once.
REQ-043 Random mem_gnt stalls of 0-20 cycles: mem_addr and mem_wdata stay stable during each stall; the transfer count is unchanged.
REQ-044 Clamp and zero: width=600, height=12 -> 5120 writes; width=0 with request_write only -> DONE within 2 cycles.
REQ-045 Reset mid-fill after 100 reads -> next cycle making_request=0 and mem_req=0; a new request then restarts at row 0, column 0.
